// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - video timing and test-pattern source feeding the filter rx stream
module video_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] pattern_sel,
    output logic [7:0] tx_red,
    output logic [7:0] tx_green,
    output logic [7:0] tx_blue,
    output logic       tx_dv,
    output logic       tx_hs,
    output logic       tx_vs,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] H_HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] V_VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [11:0] bar_pos;
    logic [2:0]  bar_idx;
    logic [1:0]  pat_reg;

    logic        h_last;
    logic        v_last;
    logic        at_origin;
    logic [1:0]  pat_eff;
    logic        dv_d;
    logic        hs_d;
    logic        vs_d;
    logic [7:0]  red_mv;
    logic [23:0] rgb_d;
    logic [11:0] bar_pos_nxt;
    logic [2:0]  bar_idx_nxt;

    always_comb begin
        h_last    = (h_cnt == H_LAST);
        v_last    = (v_cnt == V_LAST);
        at_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
        // The origin pixel already uses the newly sampled pattern.
        pat_eff   = at_origin ? pattern_sel : pat_reg;
        dv_d      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_d      = ((h_cnt >= H_HS_BEG) && (h_cnt < H_HS_END)) ? HS_POL : ~HS_POL;
        vs_d      = ((v_cnt >= V_VS_BEG) && (v_cnt < V_VS_END)) ? VS_POL : ~VS_POL;
        red_mv    = h_cnt[7:0] + frame_cnt;

        rgb_d = 24'h000000;
        case (pat_eff)
            2'd0: begin
                case (bar_idx)
                    3'd0: rgb_d = 24'hFFFFFF;
                    3'd1: rgb_d = 24'hFFFF00;
                    3'd2: rgb_d = 24'h00FFFF;
                    3'd3: rgb_d = 24'h00FF00;
                    3'd4: rgb_d = 24'hFF00FF;
                    3'd5: rgb_d = 24'hFF0000;
                    3'd6: rgb_d = 24'h0000FF;
                    default: rgb_d = 24'h000000;
                endcase
            end
            2'd1: rgb_d = {h_cnt[7:0], h_cnt[7:0], h_cnt[7:0]};
            2'd2: rgb_d = (h_cnt[3] ^ v_cnt[3]) ? 24'h000000 : 24'hFFFFFF;
            default: rgb_d = {red_mv, v_cnt[7:0], frame_cnt};
        endcase
        if (!dv_d) begin
            rgb_d = 24'h000000;
        end

        // Bar index steps every BAR_W pixels and stays on the last bar past the active area.
        bar_pos_nxt = bar_pos + 12'd1;
        bar_idx_nxt = bar_idx;
        if (h_last) begin
            bar_pos_nxt = 12'd0;
            bar_idx_nxt = 3'd0;
        end else if (bar_pos == BAR_LAST) begin
            bar_pos_nxt = 12'd0;
            bar_idx_nxt = (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            h_cnt       <= 12'd0;
            v_cnt       <= 12'd0;
            bar_pos     <= 12'd0;
            bar_idx     <= 3'd0;
            tx_red      <= 8'd0;
            tx_green    <= 8'd0;
            tx_blue     <= 8'd0;
            tx_dv       <= 1'b0;
            tx_hs       <= ~HS_POL;
            tx_vs       <= ~VS_POL;
            frame_start <= 1'b0;
            if (rst) begin
                frame_cnt <= 8'd0;
                pat_reg   <= 2'd0;
            end
        end else begin
            {tx_red, tx_green, tx_blue} <= rgb_d;
            tx_dv       <= dv_d;
            tx_hs       <= hs_d;
            tx_vs       <= vs_d;
            frame_start <= at_origin;
            bar_pos     <= bar_pos_nxt;
            bar_idx     <= bar_idx_nxt;
            if (at_origin) begin
                pat_reg <= pattern_sel;
            end
            if (h_last) begin
                h_cnt <= 12'd0;
                if (v_last) begin
                    v_cnt     <= 12'd0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    v_cnt <= v_cnt + 12'd1;
                end
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

endmodule
